regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Write-port controller for the 32×32 register file. It first sequences a clear sweep that writes zero to every register. It then shares the register file's single write port between two writeback requesters, port A (ALU writeback) and port B (load writeback), using round-robin arbitration and a valid/ready handshake. Its registered outputs drive the register file's `RegWrite`, `write_reg` and `write_data` inputs directly.

## Interface
Parameters:
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register index width
- `NUM_REGS`, 32, number of registers covered by the clear sweep; must be ≤ 2^ADDR_W

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `a_valid`  in  1  port A write request
- `a_ready`  out  1  port A request accepted this cycle
- `a_addr`  in  ADDR_W  port A destination register
- `a_data`  in  DATA_W  port A write data
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as port A, for port B
- `clr_start`  in  1  single-cycle pulse that requests a new clear sweep
- `busy`  out  1  high while a clear sweep is running
- `rf_we`  out  1  to register file `RegWrite`
- `rf_waddr`  out  ADDR_W  to register file `write_reg`
- `rf_wdata`  out  DATA_W  to register file `write_data`

## Operation
State machine:
- Two states, `CLR` and `ARB`. Reset enters `CLR` with `cnt` = 0.
- In `CLR`, on each edge:
  - `rf_we` ← 1, `rf_waddr` ← `cnt`, `rf_wdata` ← 0
  - `cnt` increments
  - when `cnt` = NUM_REGS-1, the next state is `ARB`
- In `ARB`, a `clr_start` pulse moves the block to `CLR` with `cnt` = 0 on the next edge. No grant is issued in that cycle.
- `clr_start` is ignored while in `CLR`; the sweep does not restart.
- `busy` = (state == `CLR`). `a_ready` and `b_ready` are 0 while in `CLR`.

Arbitration in `ARB`:
- A one-bit priority pointer `pri` selects the favoured port; reset value is A.
- Both ports valid: the port selected by `pri` is granted, and `pri` moves to the other port.
- One port valid: that port is granted, and `pri` moves to the other port.
- Neither port valid: no grant, and `pri` is unchanged.
- Grant rules:
  - `x_ready` is combinational and equals the grant.
  - At most one `ready` is high per cycle.
  - A handshake completes when `valid` and `ready` are both high.
- For a granted port, on the next edge: `rf_we` ← 1, `rf_waddr` ← addr, `rf_wdata` ← data.
- With no grant, `rf_we` ← 0 and `rf_waddr`/`rf_wdata` hold their values.
- Requesters hold `valid`, `addr` and `data` stable until their `ready` is seen.
- When both ports target the same register, the writes are issued in grant order, so the later grant's data persists.

## Timing
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `busy`=1, `a_ready`=`b_ready`=0, `pri`=A, `cnt`=0.
- Clear sweep:
  - Edges 1..NUM_REGS after `rst` deasserts carry `rf_we`=1 with addresses 0..NUM_REGS-1.
  - `busy` falls after edge NUM_REGS.
  - A `ready` can first be high in the cycle after edge NUM_REGS.
- Write latency is 1 cycle from handshake to `rf_we`.
- Throughput is one write per cycle; each port gets back-to-back grants when it is the only requester.
- `rst` asserted mid-sweep or mid-arbitration clears all state at once. The sweep then restarts from address 0 after `rst` is released.
- Under sustained contention, grants strictly alternate A, B, A, B.

## Configuration
- `REGWR_ZERO_GUARD_EN`
  - Defined: a handshake whose addr = 0 still completes (`ready` high) but produces `rf_we`=0 on the next edge, so register 0 stays at zero. The clear sweep still writes address 0.
  - Undefined: writes to address 0 are forwarded like any other address.

## Structure
- Package `regfile_pkg` holds:
  - state enum (`CLR`, `ARB`)
  - defaults for `DATA_W`, `ADDR_W`, `NUM_REGS`
  - port-select constants `PORT_A` / `PORT_B`
- Sub-module `rr_arbiter2` contains the two-request round-robin grant logic and the `pri` register; the top level contains the state machine, the sweep counter and the output registers.

## Test plan
- Reset, then release with no requests → 32 cycles of `rf_we`=1, addresses 0..31, data 0; `busy` falls after edge 32.
- `a_valid` only, addr 5, data 0xDEADBEEF → `a_ready` high; next edge `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF.
- A and B held valid for 4 cycles (A: addr 3/0x11, B: addr 4/0x22) → grant order A, B, A, B; `rf_waddr` sequence 3, 4, 3, 4.
- `clr_start` pulse while both ports are valid → `ready` low for 32 cycles during the sweep; arbitration resumes with the stored `pri`.
- `rst` pulsed at sweep address 17 → after release the sweep restarts at address 0.
- With `REGWR_ZERO_GUARD_EN`, a_addr 0, data 0x5 → `a_ready`=1 and next-edge `rf_we`=0. Without the macro → `rf_we`=1, `rf_waddr`=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write-port controller.
package regfile_pkg;

  typedef enum logic {
    CLR = 1'b0,
    ARB = 1'b1
  } state_t;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant logic with its priority pointer.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  logic r_pri;

  always_comb begin
    o_gnt_a = 1'b0;
    o_gnt_b = 1'b0;
    if (i_en) begin
      if (i_req_a && i_req_b) begin
        o_gnt_a = (r_pri == PORT_A);
        o_gnt_b = (r_pri == PORT_B);
      end else begin
        o_gnt_a = i_req_a;
        o_gnt_b = i_req_b;
      end
    end
  end

  // Pointer always moves away from whichever port just won; idle cycles leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pri <= PORT_A;
    end else if (o_gnt_a) begin
      r_pri <= PORT_B;
    end else if (o_gnt_b) begin
      r_pri <= PORT_A;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port controller: clear sweep, then round-robin A/B writeback.
// Optional REGWR_ZERO_GUARD_EN suppresses the write of handshakes targeting register 0.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              clr_start,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_en;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_fwd;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_en),
    .i_req_a (a_valid),
    .i_req_b (b_valid),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLR) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end else if (w_state_nxt == CLR) begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLR:     if (r_cnt == LAST_ADDR) w_state_nxt = ARB;
      ARB:     if (clr_start) w_state_nxt = CLR;
      default: w_state_nxt = CLR;
    endcase
  end

  // A clr_start cycle in ARB issues no grant, so the pointer is preserved across the sweep.
  always_comb begin
    busy    = (r_state == CLR);
    w_en    = (r_state == ARB) && !clr_start;
    a_ready = w_gnt_a;
    b_ready = w_gnt_b;
  end

  assign w_sel_addr = w_gnt_a ? a_addr : b_addr;
  assign w_sel_data = w_gnt_a ? a_data : b_data;

`ifdef REGWR_ZERO_GUARD_EN
  assign w_fwd = (w_gnt_a || w_gnt_b) && (w_sel_addr != '0);
`else
  assign w_fwd = w_gnt_a || w_gnt_b;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (r_state == CLR) begin
      r_we    <= 1'b1;
      r_waddr <= r_cnt;
      r_wdata <= '0;
    end else if (w_fwd) begin
      r_we    <= 1'b1;
      r_waddr <= w_sel_addr;
      r_wdata <= w_sel_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: reference model predicts grants and writes.
module tb_regfile_wr_arbiter;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        clr_start, busy, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  logic m_arb;
  int   m_cnt;
  logic m_pri;
  logic last_ga, last_gb;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .clr_start (clr_start),
    .busy      (busy),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_arb = 1'b0;
    m_cnt = 0;
    m_pri = 1'b0;
  endtask

  // One clock: predict readies and the next-edge write, then compare after the edge.
  task automatic step();
    exp_t e;
    logic ga, gb;
    #1;
    ga = 1'b0;
    gb = 1'b0;
    if (m_arb && !clr_start) begin
      if (a_valid && b_valid) begin
        ga = (m_pri == 1'b0);
        gb = !ga;
      end else begin
        ga = a_valid;
        gb = b_valid;
      end
    end
    chk("a_ready", {31'd0, a_ready}, {31'd0, ga});
    chk("b_ready", {31'd0, b_ready}, {31'd0, gb});
    chk("busy", {31'd0, busy}, {31'd0, !m_arb});
    e.we = 1'b0; e.addr = 5'd0; e.data = 32'd0;
    if (!m_arb) begin
      e.we = 1'b1;
      e.addr = m_cnt[4:0];
      if (m_cnt == 31) m_arb = 1'b1;
      m_cnt++;
    end else if (clr_start) begin
      m_arb = 1'b0;
      m_cnt = 0;
    end else if (ga || gb) begin
      e.addr = ga ? a_addr : b_addr;
      e.data = ga ? a_data : b_data;
      e.we   = 1'b1;
`ifdef REGWR_ZERO_GUARD_EN
      if (e.addr == 5'd0) e.we = 1'b0;
`endif
      m_pri = ga;
    end
    last_ga = ga;
    last_gb = gb;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
    if (e.we) begin
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
      chk("rf_wdata", rf_wdata, e.data);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; clr_start = 1'b0;
    a_addr = 5'd0; b_addr = 5'd0; a_data = 32'd0; b_data = 32'd0;
    last_ga = 1'b0; last_gb = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;

    // initial clear sweep plus one idle cycle after it
    repeat (33) step();

    // single A write, then single B write (pointer back to A)
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    step();
    a_valid = 1'b0;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77;
    step();
    b_valid = 1'b0;

    // sustained contention: A, B, A, B
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h22;
    repeat (4) step();

    // clear while both valid; a second pulse mid-sweep is ignored
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (10) step();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (24) step();

    // reset mid-sweep once address 17 has been written
    a_valid = 1'b0; b_valid = 1'b0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    while (m_cnt != 18) step();
    rst = 1'b1;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (33) step();

    // write to register 0
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h5;
    step();
    a_valid = 1'b0;
    step();

    // back-to-back grants to a lone requester
    b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_addr = 5'(10 + i);
      b_data = 32'hB000 + 32'(i);
      step();
    end
    b_valid = 1'b0;

    // random traffic; requests held until granted
    for (int i = 0; i < 60; i++) begin
      if (!a_valid || last_ga) begin
        a_valid = 1'($urandom_range(0, 1));
        a_addr  = 5'($urandom);
        a_data  = $urandom;
      end
      if (!b_valid || last_gb) begin
        b_valid = 1'($urandom_range(0, 1));
        b_addr  = 5'($urandom);
        b_data  = $urandom;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
